// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR bus widths, owner codes and arbiter state encoding
package csr_pkg;

    localparam int CSR_ADDR_W = 5;
    localparam int CSR_DATA_W = 8;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    function automatic logic [1:0] owner_code(input logic sel);
        return sel ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-requester round-robin selector driven by a last-served pointer
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    // On contention the requester that was not served last wins; otherwise the lone requester.
    assign valid = |req;
    assign sel   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/csr_arbiter.sv
// rtl/csr_arbiter.sv - round-robin two-master CSR bus arbiter with lock and lock timeout
module csr_arbiter
    import csr_pkg::*;
#(
    parameter int          ADDR_W       = CSR_ADDR_W,
    parameter int          DATA_W       = CSR_DATA_W,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd1023
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_a,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_a,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] csr_a,
    output logic              csr_we,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic [DATA_W-1:0] csr_rdata,

    output logic [1:0]        owner,
    output logic              lock_timeout
);

    logic [1:0]        state;
    logic              rr_last;
    logic [15:0]       tmo_cnt;

    logic              pick_valid;
    logic              pick_sel;
    logic              own_sel;
    logic              own_req;
    logic              own_lock;
    logic              tmo_hit;

    logic              grant;
    logic              grant_sel;
    logic [ADDR_W-1:0] grant_a;
    logic              grant_we;
    logic [DATA_W-1:0] grant_wdata;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (rr_last),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    assign own_sel  = (owner == OWN_M1);
    assign own_req  = own_sel ? m1_req  : m0_req;
    assign own_lock = own_sel ? m1_lock : m0_lock;

    // A zero timeout disables forced release entirely.
    assign tmo_hit = (LOCK_TIMEOUT != 16'd0) && (tmo_cnt == LOCK_TIMEOUT - 16'd1);

    // While a lock is held only the owner can be granted; the other master stalls.
    always_comb begin
        grant     = 1'b0;
        grant_sel = 1'b0;
        if (state == ST_IDLE) begin
            grant     = pick_valid;
            grant_sel = pick_sel;
        end else if (state == ST_HOLD) begin
            grant     = own_req;
            grant_sel = own_sel;
        end
    end

    assign grant_a     = grant_sel ? m1_a     : m0_a;
    assign grant_we    = grant_sel ? m1_we    : m0_we;
    assign grant_wdata = grant_sel ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            owner        <= OWN_NONE;
            csr_a        <= '0;
            csr_we       <= 1'b0;
            csr_wdata    <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            lock_timeout <= 1'b0;
            rr_last      <= 1'b1;
            tmo_cnt      <= 16'd0;
        end else begin
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            lock_timeout <= 1'b0;

            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (grant) begin
                        state     <= ST_ACCESS;
                        owner     <= owner_code(grant_sel);
                        csr_a     <= grant_a;
                        csr_we    <= grant_we;
                        csr_wdata <= grant_wdata;
                        tmo_cnt   <= 16'd0;
                    end else if (state == ST_HOLD) begin
                        if (!own_lock) begin
                            state   <= ST_IDLE;
                            owner   <= OWN_NONE;
                            tmo_cnt <= 16'd0;
                        end else if (tmo_hit) begin
                            // Stuck lock: release and hand the next round to the other master.
                            lock_timeout <= 1'b1;
                            state        <= ST_IDLE;
                            owner        <= OWN_NONE;
                            rr_last      <= own_sel;
                            tmo_cnt      <= 16'd0;
                        end else if (tmo_cnt != 16'hFFFF) begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                end

                ST_ACCESS: begin
                    csr_we <= 1'b0;
                    if (own_sel) begin
                        m1_rdata <= csr_rdata;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= csr_rdata;
                        m0_ack   <= 1'b1;
                    end
                    state <= ST_RESP;
                end

                ST_RESP: begin
                    rr_last <= own_sel;
                    tmo_cnt <= 16'd0;
                    if (own_lock) begin
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_arbiter.sv
// tb/tb_csr_arbiter.sv - self-checking bench for csr_arbiter against a transaction-level model
module tb_csr_arbiter;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       m_req  [2];
    logic       m_lock [2];
    logic [4:0] m_a    [2];
    logic       m_we   [2];
    logic [7:0] m_wd   [2];

    logic       m0_ack, m1_ack, csr_we, lock_timeout;
    logic [7:0] m0_rdata, m1_rdata, csr_wdata, csr_rdata;
    logic [4:0] csr_a;
    logic [1:0] owner;

    logic [7:0] mem [32];
    logic       load;
    logic [4:0] load_a;
    logic [7:0] load_d;

    assign csr_rdata = mem[csr_a];
    always @(posedge clk) begin
        if (load)        mem[load_a] <= load_d;
        else if (csr_we) mem[csr_a]  <= csr_wdata;
    end

    csr_arbiter #(.ADDR_W(5), .DATA_W(8), .LOCK_TIMEOUT(16'd8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m_req[0]), .m0_lock(m_lock[0]), .m0_a(m_a[0]), .m0_we(m_we[0]),
        .m0_wdata(m_wd[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m_req[1]), .m1_lock(m_lock[1]), .m1_a(m_a[1]), .m1_we(m_we[1]),
        .m1_wdata(m_wd[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .csr_a(csr_a), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .owner(owner), .lock_timeout(lock_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: sample index n counts negedges; each access is predicted from the
    // arbitration rules as grant edge -> csr_we cycle (n+1) -> ack cycle (n+2).
    int         n, acc_at, ack_at, tmo_at, next_free, idle_cnt, held, last, cur;
    logic       cur_we;
    logic [4:0] cur_a;
    logic [7:0] cur_wd;
    logic [1:0] exp_owner;
    logic [4:0] exp_a;
    logic [7:0] exp_wd;
    logic [7:0] exp_rd  [2];
    logic [7:0] ref_mem [32];
    logic       pend    [2];
    int         dut_log [$];

    task automatic model_reset();
        n = 0; acc_at = -10; ack_at = -10; tmo_at = -10; next_free = 0;
        idle_cnt = 0; held = -1; last = 1; cur = 0;
        cur_we = 0; cur_a = 0; cur_wd = 0;
        exp_owner = 2'b00; exp_a = 0; exp_wd = 0; exp_rd[0] = 0; exp_rd[1] = 0;
    endtask

    task automatic model_grant(input int x);
        cur = x; cur_we = m_we[x]; cur_a = m_a[x]; cur_wd = m_wd[x];
        acc_at = n + 1; ack_at = n + 2; next_free = n + 3; idle_cnt = 0;
        exp_owner = (x == 1) ? 2'b10 : 2'b01;
        exp_a = m_a[x]; exp_wd = m_wd[x];
    endtask

    task automatic model_step();
        if (n == acc_at) begin
            exp_rd[cur] = ref_mem[cur_a];
            if (cur_we) ref_mem[cur_a] = cur_wd;
        end
        if (n == ack_at) begin
            last = cur; idle_cnt = 0;
            if (m_lock[cur]) held = cur;
            else begin held = -1; exp_owner = 2'b00; end
        end else if (n >= next_free) begin
            if (held >= 0) begin
                if (m_req[held]) model_grant(held);
                else if (!m_lock[held]) begin
                    held = -1; exp_owner = 2'b00; next_free = n + 1;
                end else begin
                    idle_cnt++;
                    if (idle_cnt == TMO) begin
                        tmo_at = n + 1; held = -1; exp_owner = 2'b00; next_free = n + 1;
                    end
                end
            end else if (m_req[0] && m_req[1]) model_grant(1 - last);
            else if (m_req[0]) model_grant(0);
            else if (m_req[1]) model_grant(1);
        end
    endtask

    task automatic check_outputs();
        if (m0_ack) dut_log.push_back(0);
        if (m1_ack) dut_log.push_back(1);
        chk("owner",        owner,        exp_owner);
        chk("csr_a",        csr_a,        exp_a);
        chk("csr_wdata",    csr_wdata,    exp_wd);
        chk("csr_we",       csr_we,       (n == acc_at) && cur_we);
        chk("m0_ack",       m0_ack,       (n == ack_at) && (cur == 0));
        chk("m1_ack",       m1_ack,       (n == ack_at) && (cur == 1));
        chk("m0_rdata",     m0_rdata,     exp_rd[0]);
        chk("m1_rdata",     m1_rdata,     exp_rd[1]);
        chk("lock_timeout", lock_timeout, n == tmo_at);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        n++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
    endtask

    task automatic set_m(input int x, input logic r, input logic l, input logic w,
                         input logic [4:0] ad, input logic [7:0] d);
        m_req[x] = r; m_lock[x] = l; m_we[x] = w; m_a[x] = ad; m_wd[x] = d;
    endtask

    function automatic logic ack_of(input int x);
        return (x == 1) ? m1_ack : m0_ack;
    endfunction

    // Waits (bounded) for the DUT to ack master x; returns cycles waited.
    task automatic wait_ack(input int x, input string tag, output int k);
        k = 0;
        while (!ack_of(x) && k < 60) begin
            cycle();
            k++;
        end
        chk({tag, "_ack_seen"}, ack_of(x), 1'b1);
    endtask

    task automatic rand_drive(input int x);
        logic acked;
        acked = (n == ack_at) && (cur == x);
        if (pend[x] && !acked) return;
        pend[x] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            pend[x] = 1'b1;
            set_m(x, 1'b1, $urandom_range(0, 2) == 0, 1'($urandom), 5'($urandom), 8'($urandom));
        end else begin
            m_req[x]  = 1'b0;
            m_lock[x] = (held == x) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        int k;
        int a0;
        int wc;
        rst_n = 1'b0; load = 1'b0; load_a = '0; load_d = '0;
        for (int x = 0; x < 2; x++) begin
            set_m(x, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
            pend[x] = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            load = 1'b1; load_a = 5'(i);
            load_d = (i == 3) ? 8'h20 : 8'($urandom);
            ref_mem[i] = load_d;
        end
        @(negedge clk);
        load = 1'b0;
        do_reset();

        // Single m0 read of 0x03
        set_m(0, 1'b1, 1'b0, 1'b0, 5'h03, 8'h00);
        wait_ack(0, "s1", k);
        chk("s1_latency", k, 2);
        chk("s1_rdata", m0_rdata, 8'h20);
        m_req[0] = 1'b0;
        cycle();
        chk("s1_owner_after", owner, 2'b00);

        // m1 write 0xA5 to 0x0A
        set_m(1, 1'b1, 1'b0, 1'b1, 5'h0A, 8'hA5);
        k = 0; wc = 0;
        while (!m1_ack && k < 60) begin
            cycle(); k++;
            if (csr_we) begin
                wc++;
                chk("s2_csr_a", csr_a, 5'h0A);
                chk("s2_csr_wdata", csr_wdata, 8'hA5);
            end
        end
        chk("s2_latency", k, 2);
        chk("s2_we_cycles", wc, 1);
        m_req[1] = 1'b0;
        repeat (3) cycle();

        // Both request continuously from reset
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 5'h04, 8'h00);
        set_m(1, 1'b1, 1'b0, 1'b0, 5'h05, 8'h00);
        dut_log.delete();
        k = 0;
        while (dut_log.size() < 4 && k < 60) begin cycle(); k++; end
        chk("s3_ack_count", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++) chk("s3_order", dut_log[i], i % 2);
        m_req[0] = 1'b0; m_req[1] = 1'b0;
        repeat (4) cycle();

        // m0 locked over three writes while m1 waits
        dut_log.delete();
        set_m(1, 1'b1, 1'b0, 1'b0, 5'h05, 8'h00);
        for (int i = 0; i < 3; i++) begin
            set_m(0, 1'b1, 1'b1, 1'b1, 5'(8 + i), 8'($urandom));
            if (i > 0) cycle();
            wait_ack(0, "s4_m0", k);
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
        wait_ack(1, "s4_m1", k);
        m_req[1] = 1'b0;
        chk("s4_ack_count", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++) chk("s4_order", dut_log[i], (i == 3) ? 1 : 0);
        repeat (3) cycle();

        // Lock timeout: m0 takes the lock and idles, m1 waits
        set_m(0, 1'b1, 1'b1, 1'b1, 5'h11, 8'h3C);
        wait_ack(0, "s5_m0", k);
        a0 = n;
        m_req[0] = 1'b0;
        set_m(1, 1'b1, 1'b0, 1'b0, 5'h11, 8'h00);
        k = 0;
        while (!lock_timeout && k < 40) begin cycle(); k++; end
        chk("s5_tmo_seen", lock_timeout, 1'b1);
        chk("s5_tmo_delay", n - a0, TMO + 1);
        m_lock[0] = 1'b0;
        wait_ack(1, "s5_m1", k);
        chk("s5_m1_rdata", m1_rdata, 8'h3C);
        m_req[1] = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset during an m0 write access with m1 pending
        set_m(0, 1'b1, 1'b0, 1'b1, 5'h02, 8'h77);
        set_m(1, 1'b1, 1'b0, 1'b1, 5'h07, 8'h5A);
        k = 0;
        while (owner != 2'b01 && k < 20) begin cycle(); k++; end
        chk("s6_access_we", csr_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_we", csr_we, 1'b0);
        chk("s6_rst_owner", owner, 2'b00);
        chk("s6_rst_acks", {m0_ack, m1_ack}, 2'b00);
        chk("s6_rst_csr_a", csr_a, 5'h00);
        m_req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
        wait_ack(1, "s6_m1", k);
        chk("s6_latency", k, 2);
        m_req[1] = 1'b0;
        repeat (3) cycle();

        // Randomized traffic with locks and occasional timeouts
        for (int i = 0; i < 3000; i++) begin
            rand_drive(0);
            rand_drive(1);
            cycle();
        end
        for (int i = 0; i < 40; i++) begin
            for (int x = 0; x < 2; x++) begin
                if (!pend[x] || ((n == ack_at) && (cur == x))) begin
                    pend[x] = 1'b0; m_req[x] = 1'b0; m_lock[x] = 1'b0;
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
